// File: rtl/spi_result_readout.sv
// SPI mode-0 slave serving a bank of 8-bit result registers.
// All SPI pins are oversampled in the clk domain. A frame is one address
// byte followed by any number of auto-incrementing data bytes.
module spi_result_readout #(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  sck,
  input  logic                  nCS,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [8*NUM_REGS-1:0] regData,
  output logic                  rdStrobe,
  output logic [ADDR_W-1:0]     rdAddr,
  output logic                  frameErr
);
  localparam int S = SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [S-1:0]      sck_s, ncs_s, mosi_s, flush_s;
  logic              sck_rise, sck_fall, cs_hi, mosi_b;
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        mosi_sr;
  logic [7:0]        miso_sr;
  logic              hold, armed;
  logic [ADDR_W-1:0] addr, load_addr;
  logic [7:0]        shifted, load_data;

  // Synchronizers; flush_s marks when the chains hold real pin samples,
  // so a low nCS seen right after reset is not mistaken for a new frame.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      sck_s   <= '0;
      ncs_s   <= '1;
      mosi_s  <= '0;
      flush_s <= '0;
    end else begin
      sck_s   <= {sck_s[S-2:0], sck};
      ncs_s   <= {ncs_s[S-2:0], nCS};
      mosi_s  <= {mosi_s[S-2:0], mosi};
      flush_s <= {flush_s[S-2:0], 1'b1};
    end
  end

  assign sck_rise = sck_s[S-2] & ~sck_s[S-1];
  assign sck_fall = ~sck_s[S-2] & sck_s[S-1];
  assign cs_hi    = ncs_s[S-1];
  assign mosi_b   = mosi_s[S-1];

  // Address of the register to load on this byte boundary, and its value
  // (out-of-range addresses read as zero).
  always_comb begin
    shifted   = {mosi_sr, mosi_b};
    load_addr = (state == ADDR) ? ADDR_W'(shifted) : addr + ADDR_W'(1);
    load_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (load_addr == ADDR_W'(i)) load_data = regData[8*i +: 8];
  end

  // Frame FSM with shift registers and registered outputs. miso is updated
  // together with miso_sr so it follows the new MSB one clock after the edge.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      mosi_sr  <= '0;
      miso_sr  <= '0;
      hold     <= 1'b0;
      armed    <= 1'b0;
      addr     <= '0;
      miso     <= 1'b0;
      rdStrobe <= 1'b0;
      rdAddr   <= '0;
      frameErr <= 1'b0;
    end else begin
      rdStrobe <= 1'b0;
      frameErr <= 1'b0;
      armed    <= cs_hi & flush_s[S-1];
      case (state)
        IDLE: begin
          // Only a falling nCS (high seen after the flush) opens a frame.
          if (armed && !cs_hi) state <= ADDR;
        end
        default: begin
          if (cs_hi) begin
            // nCS release wins over any coincident sck edge.
            state    <= IDLE;
            frameErr <= (bit_cnt != 3'd0);
            bit_cnt  <= '0;
            mosi_sr  <= '0;
            miso_sr  <= '0;
            hold     <= 1'b0;
            miso     <= 1'b0;
          end else if (sck_rise) begin
            mosi_sr <= shifted[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // Byte boundary: snapshot the next register and hold its MSB
              // through the following fall.
              state    <= DATA;
              addr     <= load_addr;
              rdAddr   <= load_addr;
              rdStrobe <= 1'b1;
              miso_sr  <= load_data;
              miso     <= load_data[7];
              hold     <= 1'b1;
            end
          end else if (sck_fall && state == DATA) begin
            if (hold) begin
              hold <= 1'b0;
            end else begin
              miso_sr <= {miso_sr[6:0], 1'b0};
              miso    <= miso_sr[6];
            end
          end
        end
      endcase
    end
  end

endmodule
